// File: rtl/if_hart_fetch_reg_pkg.sv
// Shared types and constants for the multi-hart IF/ID stage.
// Holds the hart run-state encoding, the NOP opcode and the hart-id width helper.
package if_hart_fetch_reg_pkg;

  typedef enum logic [1:0] {
    HART_IDLE   = 2'b00,
    HART_ACTIVE = 2'b01,
    HART_PEND   = 2'b10
  } hart_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int hart_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/if_hart_fetch_reg_if.sv
// Fetch-side bus of the IF/ID stage: I-cache/BTB request and response,
// plus the registered IF/ID pipeline outputs towards decode.
interface if_hart_fetch_reg_if
  import if_hart_fetch_reg_pkg::*;
#(
  parameter int HART_NUM = 4,
  parameter int XLEN     = 32
);
  localparam int HART_ID_W = hart_id_w(HART_NUM);

  logic [XLEN-1:0]      fetch_pc;
  logic [HART_ID_W-1:0] fetch_hart_id;
  logic                 fetch_en;
  logic [HART_NUM-1:0]  hart_active;

  logic [XLEN-1:0]      insn;
  logic                 pr_br_en;
  logic [XLEN-1:0]      pr_tar_data;

  logic [XLEN-1:0]      if_pc;
  logic [XLEN-1:0]      if_npc;
  logic [XLEN-1:0]      if_insn;
  logic                 if_en;
  logic [HART_ID_W-1:0] if_hart_id;
  logic                 if_pr_br_en;
  logic [XLEN-1:0]      if_pr_tar_data;

  modport master (
    output fetch_pc, fetch_hart_id, fetch_en, hart_active,
    input  insn, pr_br_en, pr_tar_data,
    output if_pc, if_npc, if_insn, if_en, if_hart_id, if_pr_br_en, if_pr_tar_data
  );

  modport slave (
    input  fetch_pc, fetch_hart_id, fetch_en, hart_active,
    output insn, pr_br_en, pr_tar_data,
    input  if_pc, if_npc, if_insn, if_en, if_hart_id, if_pr_br_en, if_pr_tar_data
  );

endinterface

// File: rtl/if_hart_fetch_reg_hart_rr_sel.sv
// Round-robin picker: returns the first eligible index after ptr, wrapping
// modulo N, and a flag telling whether any index is eligible at all.
module hart_rr_sel
  import if_hart_fetch_reg_pkg::*;
#(
  parameter int N = 4,
  parameter int W = hart_id_w(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk offsets from farthest to nearest so the closest eligible hart is the last one written.
  always_comb begin
    int cand;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(ptr) + k) % N;
      if (eligible[cand]) begin
        idx = W'(cand);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_hart_fetch_reg.sv
// Multi-hart IF/ID stage: per-hart PC and run-state, round-robin issue,
// prioritised redirects and the registered IF/ID pipeline register.
module if_hart_fetch_reg
  import if_hart_fetch_reg_pkg::*;
#(
  parameter int          HART_NUM  = 4,
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int         HART_ID_W = hart_id_w(HART_NUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [HART_ID_W-1:0] flush_hart_id,
  input  logic [XLEN-1:0]      flush_pc,
  input  logic                 cache_miss,
  input  logic [HART_ID_W-1:0] cm_hart_id,
  input  logic [XLEN-1:0]      cm_addr,
  input  logic                 refill_done,
  input  logic [HART_ID_W-1:0] refill_hart_id,
  input  logic                 br_taken,
  input  logic [HART_ID_W-1:0] br_hart_id,
  input  logic [XLEN-1:0]      br_addr,
  input  logic                 hs_start,
  input  logic [HART_ID_W-1:0] hs_id,
  input  logic [XLEN-1:0]      hs_pc,
  input  logic                 hk_kill,
  input  logic [HART_ID_W-1:0] hk_id,
  if_hart_fetch_reg_if.master  bus
);

  hart_state_e          state     [HART_NUM];
  hart_state_e          state_nxt [HART_NUM];
  logic [XLEN-1:0]      pc        [HART_NUM];
  logic [XLEN-1:0]      pc_nxt    [HART_NUM];
  logic [HART_ID_W-1:0] ptr;

  logic [HART_NUM-1:0]  eligible;
  logic [HART_NUM-1:0]  active_vec;
  logic [HART_ID_W-1:0] sel_idx;
  logic                 sel_any;
  logic [XLEN-1:0]      sel_pc;
  logic                 bubble;

  logic [XLEN-1:0]      if_pc_q;
  logic [XLEN-1:0]      if_npc_q;
  logic [XLEN-1:0]      if_insn_q;
  logic                 if_en_q;
  logic [HART_ID_W-1:0] if_hart_id_q;
  logic                 if_pr_br_en_q;
  logic [XLEN-1:0]      if_pr_tar_data_q;

  always_comb begin
    for (int i = 0; i < HART_NUM; i++) begin
      eligible[i]   = (state[i] == HART_ACTIVE);
      active_vec[i] = (state[i] != HART_IDLE);
    end
  end

  hart_rr_sel #(
    .N (HART_NUM),
    .W (HART_ID_W)
  ) u_rr_sel (
    .eligible (eligible),
    .ptr      (ptr),
    .idx      (sel_idx),
    .any      (sel_any)
  );

  assign sel_pc = pc[sel_idx];

  // A redirect aimed at the hart being issued makes this cycle's fetch stale.
  assign bubble = !sel_any
               || (flush      && flush_hart_id == sel_idx)
               || (cache_miss && cm_hart_id    == sel_idx)
               || (br_taken   && br_hart_id    == sel_idx);

  // One event per hart wins by priority; different harts update independently.
  always_comb begin
    for (int i = 0; i < HART_NUM; i++) begin
      state_nxt[i] = state[i];
      pc_nxt[i]    = pc[i];
      if (flush && flush_hart_id == HART_ID_W'(i)) begin
        pc_nxt[i] = flush_pc;
      end else if (cache_miss && cm_hart_id == HART_ID_W'(i)) begin
        pc_nxt[i]    = cm_addr;
        state_nxt[i] = HART_PEND;
      end else if (br_taken && br_hart_id == HART_ID_W'(i)) begin
        pc_nxt[i] = br_addr;
      end else if (hk_kill && hk_id == HART_ID_W'(i)) begin
        state_nxt[i] = HART_IDLE;
      end else if (hs_start && hs_id == HART_ID_W'(i) && state[i] == HART_IDLE) begin
        pc_nxt[i]    = hs_pc;
        state_nxt[i] = HART_ACTIVE;
      end else if (refill_done && refill_hart_id == HART_ID_W'(i) && state[i] == HART_PEND) begin
        state_nxt[i] = HART_ACTIVE;
      end else if (!stall && sel_any && sel_idx == HART_ID_W'(i)) begin
        pc_nxt[i] = bus.pr_br_en ? bus.pr_tar_data : pc[i] + XLEN'(4);
      end
    end
  end

  // Hart PC file, run-states and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HART_NUM; i++) begin
        state[i] <= (i == 0) ? HART_ACTIVE : HART_IDLE;
        pc[i]    <= (i == 0) ? RESET_PC : '0;
      end
      ptr <= HART_ID_W'(HART_NUM - 1);
    end else begin
      for (int i = 0; i < HART_NUM; i++) begin
        state[i] <= state_nxt[i];
        pc[i]    <= pc_nxt[i];
      end
      if (sel_any && !stall) begin
        ptr <= sel_idx;
      end
    end
  end

  // IF/ID pipeline register; a bubble still records which hart slot it came from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc_q          <= '0;
      if_npc_q         <= '0;
      if_insn_q        <= XLEN'(NOP);
      if_en_q          <= 1'b0;
      if_hart_id_q     <= '0;
      if_pr_br_en_q    <= 1'b0;
      if_pr_tar_data_q <= '0;
    end else if (!stall) begin
      if_hart_id_q <= sel_idx;
      if (bubble) begin
        if_pc_q          <= '0;
        if_npc_q         <= '0;
        if_insn_q        <= XLEN'(NOP);
        if_en_q          <= 1'b0;
        if_pr_br_en_q    <= 1'b0;
        if_pr_tar_data_q <= '0;
      end else begin
        if_pc_q          <= sel_pc;
        if_npc_q         <= sel_pc + XLEN'(4);
        if_insn_q        <= bus.insn;
        if_en_q          <= 1'b1;
        if_pr_br_en_q    <= bus.pr_br_en;
        if_pr_tar_data_q <= bus.pr_tar_data;
      end
    end
  end

  assign bus.fetch_pc       = sel_pc;
  assign bus.fetch_hart_id  = sel_idx;
  assign bus.fetch_en       = sel_any;
  assign bus.hart_active    = active_vec;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_npc         = if_npc_q;
  assign bus.if_insn        = if_insn_q;
  assign bus.if_en          = if_en_q;
  assign bus.if_hart_id     = if_hart_id_q;
  assign bus.if_pr_br_en    = if_pr_br_en_q;
  assign bus.if_pr_tar_data = if_pr_tar_data_q;

endmodule

// File: tb/tb_if_hart_fetch_reg.sv
// Directed bench for if_hart_fetch_reg with four harts: hand-computed
// fetch/IF-ID values checked with immediate assertions after each step.
module tb_if_hart_fetch_reg;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  flush_hart_id;
  logic [31:0] flush_pc;
  logic        cache_miss;
  logic [1:0]  cm_hart_id;
  logic [31:0] cm_addr;
  logic        refill_done;
  logic [1:0]  refill_hart_id;
  logic        br_taken;
  logic [1:0]  br_hart_id;
  logic [31:0] br_addr;
  logic        hs_start;
  logic [1:0]  hs_id;
  logic [31:0] hs_pc;
  logic        hk_kill;
  logic [1:0]  hk_id;

  int compared;
  int mismatched;

  if_hart_fetch_reg_if #(.HART_NUM(4), .XLEN(32)) bus ();

  if_hart_fetch_reg #(
    .HART_NUM (4),
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .flush_hart_id  (flush_hart_id),
    .flush_pc       (flush_pc),
    .cache_miss     (cache_miss),
    .cm_hart_id     (cm_hart_id),
    .cm_addr        (cm_addr),
    .refill_done    (refill_done),
    .refill_hart_id (refill_hart_id),
    .br_taken       (br_taken),
    .br_hart_id     (br_hart_id),
    .br_addr        (br_addr),
    .hs_start       (hs_start),
    .hs_id          (hs_id),
    .hs_pc          (hs_pc),
    .hk_kill        (hk_kill),
    .hk_id          (hk_id),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then drop every one-shot request back to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    flush           = 1'b0;
    cache_miss      = 1'b0;
    refill_done     = 1'b0;
    br_taken        = 1'b0;
    hs_start        = 1'b0;
    hk_kill         = 1'b0;
    bus.pr_br_en    = 1'b0;
    bus.pr_tar_data = 32'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    flush_hart_id   = 2'd0;
    flush_pc        = 32'h0;
    cache_miss      = 1'b0;
    cm_hart_id      = 2'd0;
    cm_addr         = 32'h0;
    refill_done     = 1'b0;
    refill_hart_id  = 2'd0;
    br_taken        = 1'b0;
    br_hart_id      = 2'd0;
    br_addr         = 32'h0;
    hs_start        = 1'b0;
    hs_id           = 2'd0;
    hs_pc           = 32'h0;
    hk_kill         = 1'b0;
    hk_id           = 2'd0;
    bus.insn        = 32'h0;
    bus.pr_br_en    = 1'b0;
    bus.pr_tar_data = 32'h0;

    #2;
    checkOutput("rst_fetch_pc", bus.fetch_pc, 32'h0);
    checkOutput("rst_fetch_id", 32'(bus.fetch_hart_id), 32'd0);
    checkOutput("rst_fetch_en", 32'(bus.fetch_en), 32'd1);
    checkOutput("rst_hart_active", 32'(bus.hart_active), 32'h1);
    checkOutput("rst_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("rst_if_insn", bus.if_insn, 32'h13);
    checkOutput("rst_if_pc", bus.if_pc, 32'h0);
    checkOutput("rst_if_pr_br_en", 32'(bus.if_pr_br_en), 32'd0);

    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch from hart 0.
    bus.insn = 32'h11;
    applyStimulus();
    checkOutput("seq1_if_en", 32'(bus.if_en), 32'd1);
    checkOutput("seq1_if_pc", bus.if_pc, 32'h0);
    checkOutput("seq1_if_npc", bus.if_npc, 32'h4);
    checkOutput("seq1_if_insn", bus.if_insn, 32'h11);
    checkOutput("seq1_fetch_pc", bus.fetch_pc, 32'h4);
    bus.insn = 32'h22;
    applyStimulus();
    checkOutput("seq2_if_pc", bus.if_pc, 32'h4);
    checkOutput("seq2_if_npc", bus.if_npc, 32'h8);
    checkOutput("seq2_fetch_pc", bus.fetch_pc, 32'h8);

    // Start hart 2 at 0x100, then interleave with hart 0.
    hs_start = 1'b1; hs_id = 2'd2; hs_pc = 32'h100; bus.insn = 32'h33;
    applyStimulus();
    checkOutput("start_if_pc", bus.if_pc, 32'h8);
    checkOutput("start_if_insn", bus.if_insn, 32'h33);
    checkOutput("start_fetch_pc", bus.fetch_pc, 32'h100);
    checkOutput("start_fetch_id", 32'(bus.fetch_hart_id), 32'd2);
    checkOutput("start_hart_active", 32'(bus.hart_active), 32'h5);
    hs_start = 1'b1; hs_id = 2'd0; hs_pc = 32'h999;
    applyStimulus();
    checkOutput("rr1_if_hart_id", 32'(bus.if_hart_id), 32'd2);
    checkOutput("rr1_if_pc", bus.if_pc, 32'h100);
    checkOutput("rr1_fetch_pc", bus.fetch_pc, 32'hC);
    applyStimulus();
    checkOutput("rr2_fetch_pc", bus.fetch_pc, 32'h104);
    applyStimulus();
    checkOutput("start_ignored_fetch_pc", bus.fetch_pc, 32'h10);
    checkOutput("start_ignored_fetch_id", 32'(bus.fetch_hart_id), 32'd0);
    applyStimulus();
    checkOutput("rr4_fetch_pc", bus.fetch_pc, 32'h108);

    // Branch on the issuing hart 2 bubbles the slot.
    br_taken = 1'b1; br_hart_id = 2'd2; br_addr = 32'h200;
    applyStimulus();
    checkOutput("br_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("br_if_pc", bus.if_pc, 32'h0);
    checkOutput("br_if_npc", bus.if_npc, 32'h0);
    checkOutput("br_if_insn", bus.if_insn, 32'h13);
    checkOutput("br_if_hart_id", 32'(bus.if_hart_id), 32'd2);
    checkOutput("br_fetch_pc", bus.fetch_pc, 32'h14);
    applyStimulus();
    checkOutput("br_target_fetch_pc", bus.fetch_pc, 32'h200);
    checkOutput("br_target_fetch_id", 32'(bus.fetch_hart_id), 32'd2);
    applyStimulus();
    checkOutput("br_after_if_pc", bus.if_pc, 32'h200);
    checkOutput("br_after_fetch_pc", bus.fetch_pc, 32'h18);

    // BTB prediction on hart 0.
    bus.pr_br_en = 1'b1; bus.pr_tar_data = 32'h500;
    applyStimulus();
    checkOutput("pred_if_pr_br_en", 32'(bus.if_pr_br_en), 32'd1);
    checkOutput("pred_if_pr_tar", bus.if_pr_tar_data, 32'h500);
    checkOutput("pred_fetch_pc", bus.fetch_pc, 32'h204);
    applyStimulus();
    checkOutput("pred_target_fetch_pc", bus.fetch_pc, 32'h500);
    checkOutput("pred_clear_if_pr_br_en", 32'(bus.if_pr_br_en), 32'd0);

    // Cache miss parks hart 0; refill brings it back at the miss address.
    cache_miss = 1'b1; cm_hart_id = 2'd0; cm_addr = 32'h40;
    applyStimulus();
    checkOutput("cm_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("cm_fetch_pc", bus.fetch_pc, 32'h208);
    checkOutput("cm_hart_active", 32'(bus.hart_active), 32'h5);
    applyStimulus();
    checkOutput("cm_park_fetch_pc", bus.fetch_pc, 32'h20C);
    checkOutput("cm_park_fetch_id", 32'(bus.fetch_hart_id), 32'd2);
    refill_done = 1'b1; refill_hart_id = 2'd0;
    applyStimulus();
    checkOutput("refill_fetch_pc", bus.fetch_pc, 32'h40);
    checkOutput("refill_fetch_id", 32'(bus.fetch_hart_id), 32'd0);
    applyStimulus();
    checkOutput("refill_next_fetch_pc", bus.fetch_pc, 32'h210);

    // Flush beats branch and refill on hart 0.
    flush = 1'b1; flush_hart_id = 2'd0; flush_pc = 32'h80;
    br_taken = 1'b1; br_hart_id = 2'd0; br_addr = 32'h300;
    refill_done = 1'b1; refill_hart_id = 2'd0;
    applyStimulus();
    checkOutput("prio_if_pc", bus.if_pc, 32'h210);
    checkOutput("prio_fetch_pc", bus.fetch_pc, 32'h80);
    checkOutput("prio_hart_active", 32'(bus.hart_active), 32'h5);
    applyStimulus();
    checkOutput("prio_after_if_pc", bus.if_pc, 32'h80);
    checkOutput("prio_after_fetch_pc", bus.fetch_pc, 32'h214);

    // Stall freezes IF/ID and ptr; a branch still lands.
    stall = 1'b1; br_taken = 1'b1; br_hart_id = 2'd2; br_addr = 32'h600;
    applyStimulus();
    checkOutput("stall1_if_pc", bus.if_pc, 32'h80);
    checkOutput("stall1_if_hart_id", 32'(bus.if_hart_id), 32'd0);
    checkOutput("stall1_fetch_pc", bus.fetch_pc, 32'h600);
    applyStimulus();
    checkOutput("stall2_if_pc", bus.if_pc, 32'h80);
    checkOutput("stall2_fetch_id", 32'(bus.fetch_hart_id), 32'd2);
    applyStimulus();
    checkOutput("stall3_if_en", 32'(bus.if_en), 32'd1);
    checkOutput("stall3_fetch_pc", bus.fetch_pc, 32'h600);
    stall = 1'b0;
    applyStimulus();
    checkOutput("unstall_if_pc", bus.if_pc, 32'h600);
    checkOutput("unstall_if_hart_id", 32'(bus.if_hart_id), 32'd2);
    checkOutput("unstall_fetch_pc", bus.fetch_pc, 32'h84);

    // Kill every hart; kill beats start on the same hart.
    hk_kill = 1'b1; hk_id = 2'd0;
    applyStimulus();
    checkOutput("kill0_if_pc", bus.if_pc, 32'h84);
    checkOutput("kill0_fetch_pc", bus.fetch_pc, 32'h604);
    checkOutput("kill0_hart_active", 32'(bus.hart_active), 32'h4);
    hk_kill = 1'b1; hk_id = 2'd2;
    applyStimulus();
    checkOutput("kill2_if_en", 32'(bus.if_en), 32'd1);
    checkOutput("kill2_fetch_en", 32'(bus.fetch_en), 32'd0);
    checkOutput("kill2_hart_active", 32'(bus.hart_active), 32'h0);
    hk_kill = 1'b1; hk_id = 2'd1; hs_start = 1'b1; hs_id = 2'd1; hs_pc = 32'h700;
    applyStimulus();
    checkOutput("killstart_hart_active", 32'(bus.hart_active), 32'h0);
    checkOutput("idle_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("idle_if_insn", bus.if_insn, 32'h13);
    checkOutput("idle_if_pc", bus.if_pc, 32'h0);

    // Start hart 3, then wrap its PC past the top of the address space.
    hs_start = 1'b1; hs_id = 2'd3; hs_pc = 32'h900;
    applyStimulus();
    checkOutput("start3_hart_active", 32'(bus.hart_active), 32'h8);
    checkOutput("start3_fetch_pc", bus.fetch_pc, 32'h900);
    checkOutput("start3_fetch_id", 32'(bus.fetch_hart_id), 32'd3);
    flush = 1'b1; flush_hart_id = 2'd3; flush_pc = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("flush3_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("flush3_if_hart_id", 32'(bus.if_hart_id), 32'd3);
    checkOutput("flush3_fetch_pc", bus.fetch_pc, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_if_npc", bus.if_npc, 32'h0);
    checkOutput("wrap_fetch_pc", bus.fetch_pc, 32'h0);

    // Mid-run reset restores the power-on state.
    reset = 1'b1;
    #1;
    checkOutput("rst2_hart_active", 32'(bus.hart_active), 32'h1);
    checkOutput("rst2_fetch_pc", bus.fetch_pc, 32'h0);
    checkOutput("rst2_fetch_id", 32'(bus.fetch_hart_id), 32'd0);
    checkOutput("rst2_if_en", 32'(bus.if_en), 32'd0);
    checkOutput("rst2_if_hart_id", 32'(bus.if_hart_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
